// File: rtl/mac_stream_src.sv
// mac_stream_src: buffers operand pairs, streams them to the MAC with valid/ready/last,
// then waits (bounded) for the accumulated result beat and captures it with its flags.
module mac_stream_src #(
    parameter int int_a   = 6,
    parameter int frac_a  = 8,
    parameter int int_b   = 6,
    parameter int frac_b  = 8,
    parameter int DEPTH   = 16,
    parameter int ADDR_W  = 4,
    parameter int TIMEOUT = 64,
    localparam int AW       = int_a + frac_a,
    localparam int BW       = int_b + frac_b,
    localparam int out_int  = 2 * ((int_a > int_b) ? int_a : int_b),
    localparam int out_frac = 2 * ((frac_a > frac_b) ? frac_a : frac_b),
    localparam int RW       = out_int + out_frac
) (
    input  logic              clock,
    input  logic              rstn,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [AW-1:0]     wr_a,
    input  logic [BW-1:0]     wr_b,
    input  logic              start,
    input  logic [ADDR_W-1:0] len,
    output logic              busy,
    output logic              done,
    output logic [AW-1:0]     a,
    output logic [BW-1:0]     b,
    output logic              valid_o,
    output logic              last_o,
    input  logic              ready_i,
    input  logic [RW-1:0]     result_i,
    input  logic              valid_i,
    output logic              ready_o,
    input  logic              overflow_i,
    input  logic              underflow_i,
    output logic [RW-1:0]     result,
    output logic              ovf,
    output logic              unf,
    output logic              timeout_o
);
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] C_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {S_IDLE, S_SEND, S_WAIT, S_FIN} state_t;

    state_t            r_state;
    logic [ADDR_W-1:0] r_len;
    logic [ADDR_W-1:0] r_idx;
    logic [CW-1:0]     r_cnt;
    logic [AW-1:0]     r_mem_a [DEPTH];
    logic [BW-1:0]     r_mem_b [DEPTH];
    logic [ADDR_W-1:0] w_nxt;

    assign w_nxt = r_idx + 1'b1;

    // Buffer has no reset so contents survive an aborted transaction.
    always_ff @(posedge clock) begin
        if (r_state == S_IDLE && wr_en) begin
            r_mem_a[wr_addr] <= wr_a;
            r_mem_b[wr_addr] <= wr_b;
        end
    end

    always_ff @(posedge clock or negedge rstn) begin
        if (!rstn) begin
            r_state   <= S_IDLE;
            r_len     <= '0;
            r_idx     <= '0;
            r_cnt     <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            valid_o   <= 1'b0;
            last_o    <= 1'b0;
            ready_o   <= 1'b0;
            result    <= '0;
            ovf       <= 1'b0;
            unf       <= 1'b0;
            timeout_o <= 1'b0;
            a         <= '0;
            b         <= '0;
        end else begin
            done <= 1'b0;
            case (r_state)
                S_IDLE: if (start) begin
                    r_len     <= len;
                    r_idx     <= '0;
                    busy      <= 1'b1;
                    timeout_o <= 1'b0;
                    valid_o   <= 1'b1;
                    a         <= r_mem_a['0];
                    b         <= r_mem_b['0];
                    last_o    <= (len == '0);
                    r_state   <= S_SEND;
                end
                // valid_o is always high in SEND, so ready_i alone marks a transfer.
                S_SEND: if (ready_i) begin
                    if (last_o) begin
                        valid_o <= 1'b0;
                        last_o  <= 1'b0;
                        ready_o <= 1'b1;
                        r_cnt   <= '0;
                        r_state <= S_WAIT;
                    end else begin
                        r_idx  <= w_nxt;
                        a      <= r_mem_a[w_nxt];
                        b      <= r_mem_b[w_nxt];
                        last_o <= (w_nxt == r_len);
                    end
                end
                S_WAIT: if (valid_i) begin
                    result  <= result_i;
                    ovf     <= overflow_i;
                    unf     <= underflow_i;
                    ready_o <= 1'b0;
                    busy    <= 1'b0;
                    done    <= 1'b1;
                    r_state <= S_FIN;
                end else if (r_cnt == C_LAST) begin
                    timeout_o <= 1'b1;
                    ready_o   <= 1'b0;
                    busy      <= 1'b0;
                    done      <= 1'b1;
                    r_state   <= S_FIN;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
                S_FIN:   r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mac_stream_src.sv
// tb_mac_stream_src: randomized and directed transactions checked against a beat-list model
// of the buffer, the handshake sequence and the captured result.
module tb_mac_stream_src;
    localparam int TO = 8;

    logic        clock = 1'b0, rstn = 1'b1;
    logic        wr_en = 1'b0, start = 1'b0, ready_i = 1'b0, valid_i = 1'b0;
    logic        overflow_i = 1'b0, underflow_i = 1'b0;
    logic [3:0]  wr_addr = '0, len = '0;
    logic [13:0] wr_a = '0, wr_b = '0, a, b;
    logic [27:0] result_i = '0, result;
    logic        busy, done, valid_o, last_o, ready_o, ovf, unf, timeout_o;

    logic [13:0] m_a [16];
    logic [13:0] m_b [16];
    logic [27:0] m_res = '0;
    logic        m_ovf = 1'b0, m_unf = 1'b0;
    int          n_chk = 0, n_pass = 0;

    mac_stream_src #(.TIMEOUT(TO)) dut (
        .clock(clock), .rstn(rstn), .wr_en(wr_en), .wr_addr(wr_addr), .wr_a(wr_a), .wr_b(wr_b),
        .start(start), .len(len), .busy(busy), .done(done), .a(a), .b(b), .valid_o(valid_o),
        .last_o(last_o), .ready_i(ready_i), .result_i(result_i), .valid_i(valid_i),
        .ready_o(ready_o), .overflow_i(overflow_i), .underflow_i(underflow_i), .result(result),
        .ovf(ovf), .unf(unf), .timeout_o(timeout_o)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic load(input int ad, input logic [13:0] va, input logic [13:0] vb);
        wr_en = 1'b1; wr_addr = 4'(ad); wr_a = va; wr_b = vb;
        step();
        wr_en = 1'b0;
        m_a[ad] = va;
        m_b[ad] = vb;
    endtask

    task automatic run_txn(input int l, input logic [31:0] pat, input bit rnd, input bit respond,
                           input int dly, input bit inject, input logic [27:0] r, input bit of,
                           input bit uf);
        int k = 0;
        int cyc = 0;
        int w = 0;
        bit rdy;
        start = 1'b1; len = 4'(l);
        step();
        start = 1'b0;
        check("busy_start", busy, 1);
        check("tmo_clear", timeout_o, 0);
        while (k <= l && cyc < 200) begin
            rdy = rnd ? 1'($urandom_range(0, 1)) : ((cyc < 32) ? pat[cyc] : 1'b1);
            check("valid", valid_o, 1);
            check("a", a, m_a[k]);
            check("b", b, m_b[k]);
            check("last", last_o, 32'(k == l));
            check("ready_o_send", ready_o, 0);
            ready_i = rdy;
            if (inject && cyc == 0) begin
                start = 1'b1; len = 4'd9; wr_en = 1'b1; wr_addr = '0;
                wr_a = ~m_a[0]; wr_b = ~m_b[0];
            end
            step();
            start = 1'b0; wr_en = 1'b0;
            if (rdy) k++;
            cyc++;
        end
        ready_i = 1'b0;
        check("beats", k, l + 1);
        check("valid_end", valid_o, 0);
        check("last_end", last_o, 0);
        check("ready_o_rise", ready_o, 1);
        check("busy_wait", busy, 1);
        if (respond) begin
            repeat (dly) begin
                step();
                check("ready_o_wait", ready_o, 1);
                check("done_wait", done, 0);
            end
            valid_i = 1'b1; result_i = r; overflow_i = of; underflow_i = uf;
            step();
            valid_i = 1'b0;
            m_res = r; m_ovf = of; m_unf = uf;
            check("tmo_none", timeout_o, 0);
        end else begin
            while (!done && w < TO + 4) begin
                check("ready_o_tmo", ready_o, 1);
                step();
                w++;
            end
            check("tmo_cycles", w, TO);
            check("timeout", timeout_o, 1);
        end
        check("done", done, 1);
        check("busy_fin", busy, 0);
        check("ready_o_fin", ready_o, 0);
        check("result", result, m_res);
        check("ovf", ovf, m_ovf);
        check("unf", unf, m_unf);
        start = 1'b1;
        step();
        start = 1'b0;
        check("done_pulse", done, 0);
        check("fin_start_ign", busy, 0);
        check("fin_valid", valid_o, 0);
        check("tmo_sticky", timeout_o, 32'(!respond));
    endtask

    initial begin
        #1 rstn = 1'b0;
        #2;
        check("rst_busy", busy, 0);
        check("rst_valid", valid_o, 0);
        check("rst_ready_o", ready_o, 0);
        check("rst_result", result, 0);
        check("rst_ab", {a, b}, 0);
        check("rst_flags", {done, last_o, ovf, unf, timeout_o}, 0);
        step();
        step();
        rstn = 1'b1;
        step();
        for (int i = 0; i < 16; i++) load(i, 14'($urandom), 14'($urandom));
        load(0, 14'd256, 14'd512);
        load(1, 14'd384, 14'd512);
        load(2, 14'h3F00, 14'd512);
        load(3, 14'd128, 14'd512);
        run_txn(3, '1, 0, 1, 3, 0, 28'd196608, 0, 0);
        run_txn(3, 32'hFFFFFFE9, 0, 1, 0, 0, 28'h8000001, 1, 0);
        run_txn(2, '1, 0, 0, 0, 0, '0, 0, 0);
        run_txn(1, '1, 0, 1, 1, 0, 28'h0ABCDEF, 0, 1);
        run_txn(0, '1, 0, 1, 1, 1, 28'h1234567, 1, 1);
        run_txn(0, 32'hFFFFFFFE, 0, 1, 0, 1, 28'h7654321, 0, 0);
        run_txn(4, '1, 0, 1, TO - 1, 0, 28'h5555555, 1, 0);
        valid_i = 1'b1; result_i = 28'hFFFFFFF; overflow_i = 1'b1; underflow_i = 1'b1;
        step();
        valid_i = 1'b0;
        check("stray_ready_o", ready_o, 0);
        check("stray_result", result, m_res);
        check("stray_flags", {ovf, unf}, {m_ovf, m_unf});
        start = 1'b1; len = 4'd5; ready_i = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        check("a_idx2", a, m_a[2]);
        #2 rstn = 1'b0;
        #1;
        ready_i = 1'b0;
        m_res = '0; m_ovf = 1'b0; m_unf = 1'b0;
        check("arst_valid", valid_o, 0);
        check("arst_busy", busy, 0);
        check("arst_last", last_o, 0);
        repeat (3) begin
            step();
            check("arst_nodone", done, 0);
        end
        rstn = 1'b1;
        step();
        run_txn(5, '1, 0, 1, 2, 0, 28'h0C0FFEE, 0, 1);
        for (int t = 0; t < 12; t++) begin
            for (int i = 0; i < 4; i++) load($urandom_range(0, 15), 14'($urandom), 14'($urandom));
            run_txn($urandom_range(0, 15), '1, 1, ($urandom_range(0, 3) != 0), $urandom_range(0, TO - 1),
                    1'($urandom_range(0, 1)), 28'($urandom), 1'($urandom), 1'($urandom));
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_chk);
        $fatal(1);
    end
endmodule
